// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and helpers for the shift-register sequencer and its companions.
// Holds the FSM state encoding and the capture-length clamp rule.
package shift_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CAPT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // A request of 0 or anything wider than the register means "the whole register".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned n);
    return (len == 0 || len > n) ? n : len;
  endfunction

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Bundle between the sequencer (slave) and the logic that feeds it and consumes its word (master).
// Carries the capture request, the shift-register drive/readback and the output handshake.
interface shift_reg_ctrl_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N + 1);

  logic          start;
  logic [CW-1:0] len;
  logic          abort;
  logic          ser_in;
  logic [N-1:0]  sr_q;
  logic          sr_en;
  logic          sr_in;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready;

  modport master (
    output start, len, abort, ser_in, sr_q, out_ready,
    input  sr_en, sr_in, busy, bit_cnt, out_valid, out_data
  );

  modport slave (
    input  start, len, abort, ser_in, sr_q, out_ready,
    output sr_en, sr_in, busy, bit_cnt, out_valid, out_data
  );
endinterface

// File: rtl/shift_tick_gen.sv
// Divide-by-DIV prescaler: while running, o_tick is high for one cycle every DIV cycles.
// The tick is combinational from the count so the first tick lands on the DIV-th running cycle.
module shift_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_tick
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/shift_reg_ctrl.sv
// Sequencer for an external right-shifting SIPO register: shifts in L bits at a prescaled rate,
// then presents the captured word right-aligned over a valid/ready handshake.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input logic           clk,
  input logic           rst_n,
  shift_reg_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  state_t        r_state;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_bit_cnt;
  logic          r_busy;
  logic          r_out_valid;
  logic [N-1:0]  r_out_data;

  logic          w_in_shift;
  logic          w_tick;
  logic          w_sr_en;
  logic          w_last;
  logic [CW-1:0] w_len_eff;

  assign w_in_shift = (r_state == ST_SHIFT);

  shift_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (!w_in_shift),
    .i_run  (w_in_shift),
    .o_tick (w_tick)
  );

  // Abort suppresses the shift in the very cycle it is raised, including the final one.
  assign w_sr_en   = w_tick && !bus.abort;
  assign w_last    = (r_bit_cnt == r_len - 1'b1);
  assign w_len_eff = CW'(clamp_len(32'(bus.len), N));

  assign bus.sr_en     = w_sr_en;
  assign bus.sr_in     = w_sr_en & bus.ser_in;
  assign bus.busy      = r_busy;
  assign bus.bit_cnt   = r_bit_cnt;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_bit_cnt   <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_SHIFT;
            r_len     <= w_len_eff;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
          end else if (w_sr_en) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last) r_state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (bus.abort) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            // The newest L bits sit at the top of the register; drop the stale low part.
            r_out_data  <= bus.sr_q >> (CW'(N) - r_len);
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed plus randomized checks of shift_reg_ctrl at DIV=1 and DIV=3, each driving its own 4-bit SIPO register.
// Expected words come from the shifted bit sequence: bit i shifted in lands at word bit i.
module tb_shift_reg_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, abort = 1'b0, ser_in = 1'b0, out_ready = 1'b0;
  logic       sel = 1'b0, ld = 1'b0;
  logic [2:0] len = '0;
  logic [3:0] ld_val = '0, q1 = '0, q3 = '0;
  int         n_vec = 0, n_err = 0;

  shift_reg_ctrl_if #(.N(N)) b1 ();
  shift_reg_ctrl_if #(.N(N)) b3 ();

  shift_reg_ctrl #(.N(N), .DIV(1)) u_div1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  shift_reg_ctrl #(.N(N), .DIV(3)) u_div3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  assign b1.start = start & ~sel;
  assign b3.start = start & sel;
  assign b1.len = len;        assign b3.len = len;
  assign b1.abort = abort;    assign b3.abort = abort;
  assign b1.ser_in = ser_in;  assign b3.ser_in = ser_in;
  assign b1.out_ready = out_ready;  assign b3.out_ready = out_ready;
  assign b1.sr_q = q1;        assign b3.sr_q = q3;

  // The external shift registers: data enters at the MSB and moves toward the LSB.
  always_ff @(posedge clk) begin
    if (ld) q1 <= ld_val;
    else if (b1.sr_en) q1 <= {b1.sr_in, q1[N-1:1]};
    if (b3.sr_en) q3 <= {b3.sr_in, q3[N-1:1]};
  end

  logic       o_en, o_in, o_busy, o_valid;
  logic [2:0] o_cnt;
  logic [3:0] o_data;
  assign o_en    = sel ? b3.sr_en     : b1.sr_en;
  assign o_in    = sel ? b3.sr_in     : b1.sr_in;
  assign o_busy  = sel ? b3.busy      : b1.busy;
  assign o_valid = sel ? b3.out_valid : b1.out_valid;
  assign o_cnt   = sel ? b3.bit_cnt   : b1.bit_cnt;
  assign o_data  = sel ? b3.out_data  : b1.out_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_capture(input int l_req, input logic [3:0] bits, input int hold);
    int div, l, pulses;
    logic [3:0] exp_word;
    logic exp_en;
    div = sel ? 3 : 1;
    l = (l_req == 0 || l_req > N) ? N : l_req;
    exp_word = '0;
    for (int i = 0; i < l; i++) exp_word = exp_word + (4'(bits[i]) << i);
    pulses = 0;
    start = 1'b1;
    len = 3'(l_req);
    cyc();
    start = 1'b0;
    for (int c = 0; c < l * div; c++) begin
      ser_in = bits[c / div];
      #1;
      exp_en = ((c % div) == div - 1);
      chk("shift_en", 32'(o_en), 32'(exp_en));
      chk("shift_in", 32'(o_in), 32'(exp_en & ser_in));
      if (c == 0) chk("shift_busy", 32'(o_busy), 32'd1);
      if (o_en) pulses++;
      cyc();
    end
    #1;
    chk("pulse_count", 32'(pulses), 32'(l));
    chk("capt_en", 32'(o_en), 32'd0);
    chk("capt_valid", 32'(o_valid), 32'd0);
    cyc();
    chk("out_valid", 32'(o_valid), 32'd1);
    chk("out_data", 32'(o_data), 32'(exp_word));
    chk("bit_cnt", 32'(o_cnt), 32'(l));
    for (int h = 0; h < hold; h++) begin
      start = (h % 2 == 0);
      cyc();
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data), 32'(exp_word));
      chk("hold_busy", 32'(o_busy), 32'd1);
    end
    out_ready = 1'b1;
    start = (hold > 0);
    cyc();
    chk("done_valid", 32'(o_valid), 32'd0);
    chk("done_busy", 32'(o_busy), 32'd0);
    out_ready = 1'b0;
    start = 1'b0;
    cyc();
    chk("idle_busy", 32'(o_busy), 32'd0);
    $display("capture sel=%0d len=%0d bits=%b hold=%0d -> expected %b", sel, l_req, bits, hold, exp_word);
  endtask

  // DIV=1 only: shift `at` bits, then raise abort together with the next would-be shift.
  task automatic run_abort(input int l_req, input int at);
    start = 1'b1;
    len = 3'(l_req);
    cyc();
    start = 1'b0;
    for (int c = 0; c < at; c++) begin
      ser_in = 1'($urandom);
      #1;
      chk("pre_abort_en", 32'(o_en), 32'd1);
      cyc();
    end
    abort = 1'b1;
    #1;
    chk("abort_en", 32'(o_en), 32'd0);
    cyc();
    abort = 1'b0;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_cnt", 32'(o_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("abort_no_valid", 32'(o_valid), 32'd0);
    end
    $display("abort len=%0d after %0d shifts", l_req, at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_busy3", 32'(b3.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Reset mid-shift must clear outputs without waiting for a clock edge.
    start = 1'b1; len = 3'd4;
    cyc();
    start = 1'b0; ser_in = 1'b1;
    cyc();
    #1;
    chk("mid_en_before", 32'(o_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_en", 32'(o_en), 32'd0);
    chk("async_busy", 32'(o_busy), 32'd0);
    chk("async_valid", 32'(o_valid), 32'd0);
    chk("async_cnt", 32'(o_cnt), 32'd0);
    $display("async reset mid-shift");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    run_capture(0, 4'b1101, 0);
    ld_val = 4'b0110; ld = 1'b1;
    cyc();
    ld = 1'b0;
    run_capture(2, 4'b0011, 0);
    run_capture(7, 4'b1001, 0);

    sel = 1'b1;
    cyc();
    run_capture(4, 4'b0110, 0);
    run_capture(3, 4'b0101, 5);
    sel = 1'b0;
    cyc();
    run_capture(4, 4'b1010, 5);

    run_abort(4, 2);
    run_abort(2, 1);
    run_capture(1, 4'b0001, 1);

    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom_range(0, 1));
      cyc();
      run_capture(int'($urandom_range(0, 7)), 4'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
